// File: rtl/i2c_pkg.sv
// i2c_pkg: shared encodings for the I2C target (FSM states, bus bit
// meanings) plus a small saturating-increment helper for the byte index.
package i2c_pkg;

  // FSM state encoding, exposed on the target's debug port.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WR_BYTE   = 3'd3;
  localparam logic [2:0] ST_WR_ACK    = 3'd4;
  localparam logic [2:0] ST_RD_BYTE   = 3'd5;
  localparam logic [2:0] ST_RD_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  // Level on SDA during the acknowledge bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Meaning of the R/W bit that follows the 7-bit address.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Byte index step that sticks at the buffer capacity.
  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
    return (v < lim) ? v + 5'd1 : v;
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: the open-drain bus pins seen by the I2C target.
//
// Bus semantics: scl and sda_in are the raw, already-resolved pad levels.
// sda_oe = 1 pulls SDA low; sda_oe = 0 releases it so the pull-up (or the
// controller) sets the level. The target never drives SDA high and never
// drives SCL. There is no valid/ready handshake on this port: all timing
// comes from SCL edges observed on the system clock.
interface i2c_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  // The target listens to both lines and owns only the SDA pull-down.
  modport slave (
    input  scl,
    input  sda_in,
    output sda_oe
  );

  // The controller side owns SCL and sees the target's pull-down.
  modport master (
    output scl,
    output sda_in,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings raw SCL/SDA into the clk domain and derives the bus
// events the target FSM needs. Flops reset to 1 so an idle (pulled-up)
// bus produces no edges when reset is released.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_s;

  // Two-stage synchronisers followed by a one-cycle history register.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_raw};
    sda_sync_d = {sda_sync_q[0], sda_raw};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // Register the synchroniser chain; idle-high on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;

  // SDA may only move under a steady-high SCL for START/STOP.
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder on a sampled SCL/SDA bus. ACKs its 7-bit
// address, stores written bytes in rx_data and returns tx_data bytes on
// reads. All bus timing is derived from SCL edges seen on clk.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR      = 7'h21,
  parameter int         MAX_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_target_if.slave            bus,
  input  logic [MAX_BYTES*8-1:0] tx_data,
  output logic [MAX_BYTES*8-1:0] rx_data,
  output logic [4:0]             rx_count,
  output logic                   rw,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             state_dbg
);

  localparam logic [4:0] IDX_MAX = 5'(MAX_BYTES);

  // Bus events from the synchroniser.
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (reset),
    .scl_raw   (bus.scl),
    .sda_raw   (bus.sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // FSM and datapath registers.
  logic [2:0]             state_q,    state_d;
  logic [3:0]             bit_cnt_q,  bit_cnt_d;
  logic [7:0]             shift_q,    shift_d;
  logic [4:0]             idx_q,      idx_d;
  logic                   phase_q,    phase_d;    // second half of an ACK slot
  logic                   nack_q,     nack_d;     // write byte arrived with buffer full
  logic                   matched_q,  matched_d;  // last address was ours
  logic                   rw_q,       rw_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic                   sda_oe_q,   sda_oe_d;
  logic [MAX_BYTES*8-1:0] rx_data_q,  rx_data_d;
  logic [4:0]             rx_count_q, rx_count_d;

  // Byte assembled from the shift register plus the bit on this rise.
  logic [7:0] rx_byte;
  // Byte to transmit at the current index; out-of-range reads return 8'hFF.
  logic [7:0] tx_byte;

  // Incoming byte view for address and write data.
  always_comb begin
    rx_byte = {shift_q[6:0], sda_s};
  end

  // Read payload selection by byte index.
  always_comb begin
    tx_byte = 8'hFF;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == 5'(i)) tx_byte = tx_data[i*8 +: 8];
    end
  end

  // Next-state logic: START/STOP take priority over per-state SCL edges.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    nack_d     = nack_q;
    matched_d  = matched_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_count_d = rx_count_q;

    if (start_det) begin
      // (Repeated) START: begin a fresh address phase. busy is held so a
      // write/read pair joined by a repeated START looks like one transfer.
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      shift_d   = 8'h00;
      phase_d   = 1'b0;
      matched_d = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      matched_d = 1'b0;
      if (matched_q) begin
        done_d = 1'b1;
        if (rw_q == RW_WRITE) rx_count_d = idx_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (rx_byte[7:1] == ADDR) begin
                state_d   = ST_ADDR_ACK;
                rw_d      = rx_byte[0];
                idx_d     = 5'd0;
                matched_d = 1'b1;
                phase_d   = 1'b0;
              end else begin
                state_d = ST_WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              // Fall that ends the R/W bit: pull SDA low for the ACK.
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              phase_d  = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (rw_q == RW_WRITE) begin
                sda_oe_d  = 1'b0;
                bit_cnt_d = 4'd0;
                state_d   = ST_WR_BYTE;
              end else begin
                // Put the first read bit (MSB) on the bus right away.
                sda_oe_d  = ~tx_byte[7];
                shift_d   = {tx_byte[6:0], 1'b0};
                bit_cnt_d = 4'd1;
                state_d   = ST_RD_BYTE;
              end
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = ST_WR_ACK;
              phase_d = 1'b0;
              if (idx_q < IDX_MAX) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                  if (idx_q == 5'(i)) rx_data_d[i*8 +: 8] = rx_byte;
                end
                idx_d  = sat_inc(idx_q, IDX_MAX);
                nack_d = 1'b0;
              end else begin
                nack_d = 1'b1;
              end
            end
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              if (nack_q) begin
                // Buffer already full: leave SDA high (NACK) and drop the byte.
                sda_oe_d = 1'b0;
                state_d  = ST_WAIT_STOP;
              end else begin
                sda_oe_d = 1'b1;
                phase_d  = 1'b1;
              end
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_WR_BYTE;
            end
          end
        end

        ST_RD_BYTE: begin
          // bit_cnt counts bits already placed on the bus for this byte.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = ST_RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (sda_s == I2C_ACK) begin
              phase_d = 1'b1;
              idx_d   = sat_inc(idx_q, IDX_MAX);
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            sda_oe_d  = ~tx_byte[7];
            shift_d   = {tx_byte[6:0], 1'b0};
            bit_cnt_d = 4'd1;
            state_d   = ST_RD_BYTE;
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      idx_q      <= 5'd0;
      phase_q    <= 1'b0;
      nack_q     <= 1'b0;
      matched_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_count_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      nack_q     <= nack_d;
      matched_q  <= matched_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_count   = rx_count_q;
  assign rw         = rw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bench-side I2C controller driving i2c_target through an
// open-drain bus model, with a byte-level reference model of the target.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] ADDR = 7'h21;
  localparam int         MAXB = 16;
  localparam int         QTR  = 4;   // clk cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              m_scl;
  logic              m_oe;
  logic [MAXB*8-1:0] tx_data;
  logic [MAXB*8-1:0] rx_data;
  logic [4:0]        rx_count;
  logic              rw;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  i2c_target_if bus ();
  assign bus.scl    = m_scl;
  assign bus.sda_in = ~(m_oe | bus.sda_oe);

  i2c_target #(.ADDR(ADDR), .MAX_BYTES(MAXB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_count  (rx_count),
    .rw        (rw),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  int   done_cnt   = 0;
  int   oe_cycles  = 0;
  int   busy_gap   = 0;
  int   done_viol  = 0;
  bit   watch_busy = 1'b0;
  logic prev_busy  = 1'b0;

  // Bus/output monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (bus.sda_oe) oe_cycles++;
    if (watch_busy && !busy) busy_gap++;
    if (done && (busy || !prev_busy)) done_viol++;
    prev_busy = busy;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    if (m_scl == 1'b0) begin
      m_oe = 1'b0; q();
      m_scl = 1'b1; q();
    end
    m_oe = 1'b1; q();
    m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; q();
    m_scl = 1'b1; q();
    m_oe = 1'b0; q(); q();
  endtask

  task automatic put_bit(input logic b);
    m_oe = ~b; q();
    m_scl = 1'b1; q(); q();
    m_scl = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0; q();
    m_scl = 1'b1; q();
    b = bus.sda_in; q();
    m_scl = 1'b0; q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic last);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(last);
  endtask

  // ---------------- transaction layer ----------------
  logic [7:0] wr_buf [0:31];
  logic [7:0] rd_buf [0:31];
  logic       addr_ack_r;
  int         data_acks_r;
  logic       data_nack_r;

  task automatic xfer(input logic [6:0] a, input logic rd, input int n);
    logic       ak;
    logic [7:0] d;
    data_acks_r = 0;
    data_nack_r = 1'b0;
    bus_start();
    put_byte({a, rd}, ak);
    addr_ack_r = ak;
    if (ak == I2C_ACK) begin
      if (rd == RW_READ) begin
        for (int k = 0; k < n; k++) begin
          get_byte(d, (k == n - 1));
          rd_buf[k] = d;
        end
      end else begin
        for (int k = 0; k < n; k++) begin
          put_byte(wr_buf[k], ak);
          if (ak == I2C_NACK) begin
            data_nack_r = 1'b1;
            break;
          end
          data_acks_r++;
        end
      end
    end
    bus_stop();
    repeat (4) @(negedge clk);
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] ref_rx [0:MAXB-1];
  int         ref_count;
  logic       ref_rw;
  logic [7:0] exp_q [$];

  function automatic logic [MAXB*8-1:0] ref_vec();
    logic [MAXB*8-1:0] v;
    for (int i = 0; i < MAXB; i++) v[i*8 +: 8] = ref_rx[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAXB; i++) ref_rx[i] = 8'h00;
    ref_count = 0;
    ref_rw    = 1'b0;
  endtask

  // Byte-level view: the target ACKs its address, keeps the first MAXB
  // written bytes, serves tx bytes (then 8'hFF) and pulses done once.
  task automatic model_and_check(input string tag, input logic [6:0] a, input logic rd,
                                 input int n, input int done_before, input int oe_before);
    bit         hit;
    int         stored;
    logic [7:0] e;
    hit = (a == ADDR);
    check({tag, "_addr_ack"}, addr_ack_r, hit ? I2C_ACK : I2C_NACK);
    if (hit && rd == RW_WRITE) begin
      stored = (n < MAXB) ? n : MAXB;
      for (int k = 0; k < stored; k++) ref_rx[k] = wr_buf[k];
      ref_count = stored;
      check({tag, "_data_acks"}, data_acks_r, stored);
      check({tag, "_overflow_nack"}, data_nack_r, (n > MAXB));
    end
    if (hit && rd == RW_READ) begin
      for (int k = 0; k < n; k++) begin
        if (k < MAXB) exp_q.push_back(tx_data[k*8 +: 8]);
        else exp_q.push_back(8'hFF);
      end
      for (int k = 0; k < n; k++) begin
        e = exp_q.pop_front();
        check({tag, $sformatf("_rd%0d", k)}, rd_buf[k], e);
      end
    end
    if (hit) ref_rw = rd;
    else check({tag, "_no_drive"}, oe_cycles - oe_before, 0);
    check({tag, "_done"}, done_cnt - done_before, hit ? 1 : 0);
    check({tag, "_rx_data"}, rx_data, ref_vec());
    check({tag, "_rx_count"}, rx_count, ref_count);
    check({tag, "_rw"}, rw, ref_rw);
    check({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  // ---------------- table of directed transactions ----------------
  typedef struct {
    logic [6:0] addr;
    logic       rd;
    int         n;
    logic       exp_ack;
    int         exp_done;
    int         exp_count;
  } vec_t;

  vec_t tbl [6];

  // ---------------- main sequence ----------------
  initial begin : main
    int         db, ob;
    logic       ak;
    logic [7:0] b, d;

    reset   = 1'b0;
    m_scl   = 1'b1;
    m_oe    = 1'b0;
    tx_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_sda_oe", bus.sda_oe, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check("rst_rx_count", rx_count, 5'd0);
    check("rst_rw", rw, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: two-byte write
    wr_buf[0] = 8'hF0; wr_buf[1] = 8'hA0;
    db = done_cnt; ob = oe_cycles;
    xfer(ADDR, RW_WRITE, 2);
    model_and_check("wr2", ADDR, RW_WRITE, 2, db, ob);
    check("wr2_low16", rx_data[15:0], 16'hA0F0);

    // 2: write to another address
    wr_buf[0] = 8'h55; wr_buf[1] = 8'h66;
    db = done_cnt; ob = oe_cycles;
    xfer(7'h22, RW_WRITE, 2);
    model_and_check("wr_other", 7'h22, RW_WRITE, 2, db, ob);

    // 3: four-byte read
    tx_data[31:0] = 32'h44332211;
    db = done_cnt; ob = oe_cycles;
    xfer(ADDR, RW_READ, 4);
    model_and_check("rd4", ADDR, RW_READ, 4, db, ob);
    check("rd4_first", rd_buf[0], 8'h11);

    // 4: seventeen-byte write overflows the buffer
    for (int k = 0; k < 17; k++) wr_buf[k] = 8'($urandom_range(0, 255));
    db = done_cnt; ob = oe_cycles;
    xfer(ADDR, RW_WRITE, 17);
    model_and_check("wr17", ADDR, RW_WRITE, 17, db, ob);

    // 5: write one byte, repeated START, read one byte
    b = 8'($urandom_range(0, 255));
    tx_data[7:0] = 8'($urandom_range(0, 255));
    db = done_cnt;
    bus_start();
    put_byte({ADDR, RW_WRITE}, ak);
    check("rs_addr_w_ack", ak, I2C_ACK);
    busy_gap = 0;
    watch_busy = 1'b1;
    put_byte(b, ak);
    check("rs_data_ack", ak, I2C_ACK);
    bus_start();
    put_byte({ADDR, RW_READ}, ak);
    check("rs_addr_r_ack", ak, I2C_ACK);
    get_byte(d, 1'b1);
    watch_busy = 1'b0;
    check("rs_busy_held", busy_gap, 0);
    check("rs_no_early_done", done_cnt - db, 0);
    bus_stop();
    repeat (4) @(negedge clk);
    ref_rx[0] = b;
    ref_rw = RW_READ;
    check("rs_rd_byte", d, tx_data[7:0]);
    check("rs_rx_data", rx_data, ref_vec());
    check("rs_rx_count_kept", rx_count, ref_count);
    check("rs_rw", rw, RW_READ);
    check("rs_done", done_cnt - db, 1);

    // 6a: reset during the 5th bit of a written byte
    bus_start();
    put_byte({ADDR, RW_WRITE}, ak);
    for (int i = 0; i < 4; i++) put_bit(1'b0);
    m_oe = 1'b0; q();
    m_scl = 1'b1; q();
    check("rst5_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("rst5_sda_oe", bus.sda_oe, 1'b0);
    check("rst5_busy", busy, 1'b0);
    check("rst5_rx_data", rx_data, '0);
    check("rst5_rx_count", rx_count, 5'd0);
    m_scl = 1'b1; m_oe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);

    // 6b: reset while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 0 ? RW_WRITE : ADDR[i-1]);
    check("rstack_oe_before", bus.sda_oe, 1'b1);
    reset = 1'b0;
    #1;
    check("rstack_sda_oe", bus.sda_oe, 1'b0);
    m_scl = 1'b1; m_oe = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 6c: the next valid write succeeds
    for (int k = 0; k < 3; k++) wr_buf[k] = 8'($urandom_range(0, 255));
    db = done_cnt; ob = oe_cycles;
    xfer(ADDR, RW_WRITE, 3);
    model_and_check("post_rst", ADDR, RW_WRITE, 3, db, ob);

    // Table-driven transactions with hand-computed expectations.
    tbl[0] = '{addr: 7'h21, rd: 1'b0, n: 3,  exp_ack: 1'b0, exp_done: 1, exp_count: 3};
    tbl[1] = '{addr: 7'h21, rd: 1'b1, n: 2,  exp_ack: 1'b0, exp_done: 1, exp_count: 3};
    tbl[2] = '{addr: 7'h35, rd: 1'b0, n: 2,  exp_ack: 1'b1, exp_done: 0, exp_count: 3};
    tbl[3] = '{addr: 7'h21, rd: 1'b0, n: 0,  exp_ack: 1'b0, exp_done: 1, exp_count: 0};
    tbl[4] = '{addr: 7'h21, rd: 1'b1, n: 18, exp_ack: 1'b0, exp_done: 1, exp_count: 0};
    tbl[5] = '{addr: 7'h20, rd: 1'b1, n: 1,  exp_ack: 1'b1, exp_done: 0, exp_count: 0};
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 32; k++) wr_buf[k] = 8'($urandom_range(0, 255));
      for (int w = 0; w < MAXB / 4; w++) tx_data[w*32 +: 32] = $urandom;
      db = done_cnt; ob = oe_cycles;
      xfer(tbl[t].addr, tbl[t].rd, tbl[t].n);
      check($sformatf("tbl%0d_ack", t), addr_ack_r, tbl[t].exp_ack);
      check($sformatf("tbl%0d_done", t), done_cnt - db, tbl[t].exp_done);
      check($sformatf("tbl%0d_count", t), rx_count, tbl[t].exp_count);
      model_and_check($sformatf("tbl%0d", t), tbl[t].addr, tbl[t].rd, tbl[t].n, db, ob);
    end

    // Randomised transactions against the reference model.
    for (int r = 0; r < 10; r++) begin
      logic [6:0] a;
      logic       rdr;
      int         n;
      a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR;
      rdr = 1'($urandom_range(0, 1));
      n   = (rdr == RW_READ) ? $urandom_range(1, 18) : $urandom_range(0, 18);
      for (int k = 0; k < 32; k++) wr_buf[k] = 8'($urandom_range(0, 255));
      for (int w = 0; w < MAXB / 4; w++) tx_data[w*32 +: 32] = $urandom;
      db = done_cnt; ob = oe_cycles;
      xfer(a, rdr, n);
      model_and_check($sformatf("rnd%0d", r), a, rdr, n, db, ob);
    end

    check("done_with_busy_drop", done_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Time bound so a stuck sequence still reports.
  initial begin : watchdog
    #900us;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
